branch_predictor_sa: RTL and testbench



---
 rtl/branch_predictor_sa_if.sv | 22 ++
 rtl/branch_predictor_sa.sv | 105 ++++++++++
 tb/tb_branch_predictor_sa.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_sa_if.sv
// Fetch-side lookup and execute-side update signals for the set-associative BTB.
// The master drives PCs and resolved outcomes; the slave (the predictor) returns predictions.
interface branch_predictor_sa_if;
  logic [31:0] PC_F;
  logic        PrPCSrc_F;
  logic [31:0] PrALUResult_F;
  logic        PrHit_F;
  logic        Update_E;
  logic [31:0] PC_E;
  logic        PCSrc_E;
  logic [31:0] ALUResult_E;
  logic        Flush;

  modport master (
    output PC_F, Update_E, PC_E, PCSrc_E, ALUResult_E, Flush,
    input  PrPCSrc_F, PrALUResult_F, PrHit_F
  );
  modport slave (
    input  PC_F, Update_E, PC_E, PCSrc_E, ALUResult_E, Flush,
    output PrPCSrc_F, PrALUResult_F, PrHit_F
  );
endinterface

// File: rtl/branch_predictor_sa.sv
// N-way set-associative BTB with saturating direction counters and per-set round-robin
// replacement. Combinational lookup at fetch, registered update at execute resolution.
module branch_predictor_sa #(
  parameter int SET_BITS = 3,
  parameter int WAYS     = 2,
  parameter int CTR_BITS = 2
) (
  input logic                  clk,
  input logic                  RESETn,
  branch_predictor_sa_if.slave bp
);
  localparam int SETS     = 2 ** SET_BITS;
  localparam int TAG_BITS = 30 - SET_BITS;
  localparam int RR_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  logic [WAYS-1:0]     r_valid [SETS];
  logic [TAG_BITS-1:0] r_tag   [SETS][WAYS];
  logic [31:0]         r_tgt   [SETS][WAYS];
  logic [CTR_BITS-1:0] r_ctr   [SETS][WAYS];
  logic [RR_BITS-1:0]  r_rr    [SETS];

  logic [SET_BITS-1:0] w_idx_f, w_idx_e;
  logic [TAG_BITS-1:0] w_tag_f, w_tag_e;
  logic [WAYS-1:0]     w_hv_f, w_hv_e;
  logic [RR_BITS-1:0]  w_way_f, w_way_e, w_inv_way, w_vict;
  logic                w_inv_any, w_hit_f, w_hit_e, w_taken_f;
  logic [CTR_BITS-1:0] w_ctr_f, w_ctr_e;

  assign w_idx_f = bp.PC_F[SET_BITS+1:2];
  assign w_tag_f = bp.PC_F[31:SET_BITS+2];
  assign w_idx_e = bp.PC_E[SET_BITS+1:2];
  assign w_tag_e = bp.PC_E[31:SET_BITS+2];

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    assign w_hv_f[g] = r_valid[w_idx_f][g] && (r_tag[w_idx_f][g] == w_tag_f);
    assign w_hv_e[g] = r_valid[w_idx_e][g] && (r_tag[w_idx_e][g] == w_tag_e);
  end

  // Scan high-to-low so the lowest-numbered matching/invalid way is the one kept.
  always_comb begin
    w_way_f   = '0;
    w_way_e   = '0;
    w_inv_way = '0;
    w_inv_any = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_hv_f[w]) w_way_f = RR_BITS'(w);
      if (w_hv_e[w]) w_way_e = RR_BITS'(w);
      if (!r_valid[w_idx_e][w]) begin
        w_inv_way = RR_BITS'(w);
        w_inv_any = 1'b1;
      end
    end
  end

  assign w_vict    = w_inv_any ? w_inv_way : r_rr[w_idx_e];
  assign w_hit_f   = |w_hv_f;
  assign w_hit_e   = |w_hv_e;
  assign w_ctr_f   = r_ctr[w_idx_f][w_way_f];
  assign w_ctr_e   = r_ctr[w_idx_e][w_way_e];
  assign w_taken_f = w_hit_f && w_ctr_f[CTR_BITS-1];

  assign bp.PrHit_F       = w_hit_f;
  assign bp.PrPCSrc_F     = w_taken_f;
  assign bp.PrALUResult_F = w_taken_f ? r_tgt[w_idx_f][w_way_f] : 32'h0;

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_rr[s]    <= '0;
        for (int w = 0; w < WAYS; w++) begin
          r_tag[s][w] <= '0;
          r_tgt[s][w] <= '0;
          r_ctr[s][w] <= CTR_WNT;
        end
      end
    end else if (bp.Flush) begin
      // Targets and counters are left stale; only valid bits and rr matter.
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else if (bp.Update_E) begin
      if (w_hit_e) begin
        if (bp.PCSrc_E) begin
          if (w_ctr_e != CTR_MAX) r_ctr[w_idx_e][w_way_e] <= w_ctr_e + CTR_BITS'(1);
          r_tgt[w_idx_e][w_way_e] <= bp.ALUResult_E;
        end else if (w_ctr_e != '0) begin
          r_ctr[w_idx_e][w_way_e] <= w_ctr_e - CTR_BITS'(1);
        end
      end else if (bp.PCSrc_E) begin
        r_valid[w_idx_e][w_vict] <= 1'b1;
        r_tag[w_idx_e][w_vict]   <= w_tag_e;
        r_tgt[w_idx_e][w_vict]   <= bp.ALUResult_E;
        r_ctr[w_idx_e][w_vict]   <= CTR_WT;
        if (!w_inv_any)
          r_rr[w_idx_e] <= (r_rr[w_idx_e] == RR_BITS'(WAYS - 1)) ? '0
                                                               : r_rr[w_idx_e] + RR_BITS'(1);
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor_sa.sv
// Randomized + directed bench for branch_predictor_sa against a behavioural BTB model.
module tb_branch_predictor_sa;
  localparam int SB   = 3;
  localparam int W    = 2;
  localparam int CB   = 2;
  localparam int NS   = 2 ** SB;
  localparam int CMAX = 2 ** CB - 1;
  localparam int CWT  = 2 ** (CB - 1);

  logic clk = 1'b0;
  logic RESETn;
  int   n_checks = 0;
  int   n_fail   = 0;

  branch_predictor_sa_if bif ();

  branch_predictor_sa #(.SET_BITS(SB), .WAYS(W), .CTR_BITS(CB)) dut (
    .clk(clk), .RESETn(RESETn), .bp(bif)
  );

  always #5 clk = ~clk;

  // Model: each set holds up to W entries {valid, pc-tag, target, counter} plus a rotation pointer.
  bit          m_v   [NS][W];
  logic [31:0] m_tag [NS][W];
  logic [31:0] m_tgt [NS][W];
  int          m_ctr [NS][W];
  int          m_rr  [NS];

  function automatic int set_of(logic [31:0] pc);
    return int'(pc[SB+1:2]);
  endfunction

  function automatic logic [31:0] tag_of(logic [31:0] pc);
    return pc >> (SB + 2);
  endfunction

  function automatic int find(logic [31:0] pc);
    int s = set_of(pc);
    for (int w = 0; w < W; w++)
      if (m_v[s][w] && m_tag[s][w] == tag_of(pc)) return w;
    return -1;
  endfunction

  task automatic m_predict(input logic [31:0] pc, output bit hit, output bit tk,
                           output logic [31:0] tgt);
    int w = find(pc);
    hit = (w >= 0);
    tk  = hit && (m_ctr[set_of(pc)][w] >= CWT);
    tgt = tk ? m_tgt[set_of(pc)][w] : 32'h0;
  endtask

  task automatic m_reset();
    for (int s = 0; s < NS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < W; w++) begin
        m_v[s][w] = 0; m_tag[s][w] = 0; m_tgt[s][w] = 0; m_ctr[s][w] = CWT - 1;
      end
    end
  endtask

  task automatic m_update();
    int s, w, v;
    if (bif.Flush) begin
      for (int i = 0; i < NS; i++) begin
        m_rr[i] = 0;
        for (int j = 0; j < W; j++) m_v[i][j] = 0;
      end
    end else if (bif.Update_E) begin
      s = set_of(bif.PC_E);
      w = find(bif.PC_E);
      if (w >= 0) begin
        if (bif.PCSrc_E) begin
          m_ctr[s][w] = (m_ctr[s][w] + 1 > CMAX) ? CMAX : m_ctr[s][w] + 1;
          m_tgt[s][w] = bif.ALUResult_E;
        end else begin
          m_ctr[s][w] = (m_ctr[s][w] == 0) ? 0 : m_ctr[s][w] - 1;
        end
      end else if (bif.PCSrc_E) begin
        v = -1;
        for (int j = W - 1; j >= 0; j--) if (!m_v[s][j]) v = j;
        if (v < 0) begin
          v = m_rr[s];
          m_rr[s] = (m_rr[s] + 1) % W;
        end
        m_v[s][v] = 1; m_tag[s][v] = tag_of(bif.PC_E);
        m_tgt[s][v] = bif.ALUResult_E; m_ctr[s][v] = CWT;
      end
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One cycle: compare outputs vs model mid-cycle, then advance model at the edge.
  task automatic step();
    bit hit, tk;
    logic [31:0] tgt;
    @(negedge clk);
    if (RESETn) begin
      m_predict(bif.PC_F, hit, tk, tgt);
      check("hit",    {31'b0, bif.PrHit_F},   {31'b0, hit});
      check("taken",  {31'b0, bif.PrPCSrc_F}, {31'b0, tk});
      check("target", bif.PrALUResult_F,      tgt);
    end
    @(posedge clk);
    if (!RESETn) m_reset(); else m_update();
    #1;
  endtask

  // Literal expectation, pinned against both the DUT and the model.
  task automatic lit(input string nm, input logic [31:0] pc, input bit hit,
                     input bit tk, input logic [31:0] tgt);
    bit mh, mt;
    logic [31:0] mg;
    bif.PC_F = pc;
    #1;
    m_predict(pc, mh, mt, mg);
    check({nm, ".hit"},  {31'b0, bif.PrHit_F},   {31'b0, hit});
    check({nm, ".tk"},   {31'b0, bif.PrPCSrc_F}, {31'b0, tk});
    check({nm, ".tgt"},  bif.PrALUResult_F,      tgt);
    check({nm, ".mdl"},  {mh, mt, mg[29:0]},     {hit, tk, tgt[29:0]});
  endtask

  task automatic upd(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
    bif.Update_E = 1'b1; bif.PC_E = pc; bif.PCSrc_E = tk; bif.ALUResult_E = tgt;
    step();
    bif.Update_E = 1'b0;
  endtask

  initial begin
    RESETn = 1'b0;
    bif.PC_F = 32'h40; bif.Update_E = 1'b0; bif.PC_E = '0;
    bif.PCSrc_E = 1'b0; bif.ALUResult_E = '0; bif.Flush = 1'b0;
    m_reset();
    step(); step();
    RESETn = 1'b1;
    step();
    lit("reset", 32'h40, 0, 0, 32'h0);

    // First allocation: invisible during its own cycle, visible the next.
    bif.Update_E = 1'b1; bif.PC_E = 32'h40; bif.PCSrc_E = 1'b1; bif.ALUResult_E = 32'h100;
    lit("same_cycle", 32'h40, 0, 0, 32'h0);
    step();
    bif.Update_E = 1'b0;
    lit("alloc", 32'h40, 1, 1, 32'h100);

    // Same set: fill both ways, then round-robin eviction.
    upd(32'h60, 1, 32'h160);
    lit("way1", 32'h60, 1, 1, 32'h160);
    lit("way0", 32'h40, 1, 1, 32'h100);
    upd(32'h80, 1, 32'h180);
    lit("evict40", 32'h40, 0, 0, 32'h0);
    lit("keep60", 32'h60, 1, 1, 32'h160);
    lit("new80", 32'h80, 1, 1, 32'h180);
    upd(32'hA0, 1, 32'h1A0);
    lit("evict60", 32'h60, 0, 0, 32'h0);
    lit("newA0", 32'hA0, 1, 1, 32'h1A0);
    lit("keep80", 32'h80, 1, 1, 32'h180);

    // Counter behaviour and saturation.
    upd(32'h104, 1, 32'h300);
    upd(32'h104, 0, 32'h0);
    lit("weak_nt", 32'h104, 1, 0, 32'h0);
    for (int i = 0; i < 4; i++) upd(32'h104, 1, 32'h300);
    upd(32'h104, 1, 32'h200);
    lit("new_tgt", 32'h104, 1, 1, 32'h200);
    upd(32'h104, 0, 32'h0);
    lit("saturated", 32'h104, 1, 1, 32'h200);
    lit("pc_lowbits", 32'h107, 1, 1, 32'h200);

    // Not-taken miss does not allocate.
    upd(32'hC0, 0, 32'h999);
    lit("nt_miss", 32'hC0, 0, 0, 32'h0);

    // Flush wins over a simultaneous update.
    bif.Flush = 1'b1;
    upd(32'h1C0, 1, 32'h444);
    bif.Flush = 1'b0;
    lit("fl_A0", 32'hA0, 0, 0, 32'h0);
    lit("fl_104", 32'h104, 0, 0, 32'h0);
    lit("fl_1C0", 32'h1C0, 0, 0, 32'h0);

    // Asynchronous reset between edges clears outputs immediately.
    upd(32'h40, 1, 32'h500);
    lit("pre_rst", 32'h40, 1, 1, 32'h500);
    #2;
    RESETn = 1'b0;
    #1;
    check("async_rst.hit", {31'b0, bif.PrHit_F}, 32'h0);
    check("async_rst.tgt", bif.PrALUResult_F, 32'h0);
    upd(32'h48, 1, 32'h600);
    RESETn = 1'b1;
    lit("rst_abort", 32'h48, 0, 0, 32'h0);

    // Random traffic over a small PC pool to force conflicts and evictions.
    for (int c = 0; c < 3000; c++) begin
      bif.PC_F        = ({26'b0, 6'($urandom_range(0, 63))} << 2) | 32'($urandom_range(0, 3))
                        | (32'($urandom_range(0, 1)) << 31);
      bif.PC_E        = ({26'b0, 6'($urandom_range(0, 63))} << 2) | 32'($urandom_range(0, 3))
                        | (32'($urandom_range(0, 1)) << 31);
      bif.Update_E    = ($urandom_range(0, 1) == 1);
      bif.PCSrc_E     = ($urandom_range(0, 9) < 6);
      bif.ALUResult_E = $urandom;
      bif.Flush       = ($urandom_range(0, 99) < 2);
      RESETn          = ($urandom_range(0, 199) != 0);
      step();
    end
    RESETn = 1'b1;
    bif.Update_E = 1'b0; bif.Flush = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
